// File: rtl/lwe_pkg.sv
// rtl/lwe_pkg.sv - shared LWE modulus/width defaults, message scale shift and FSM state encodings
package lwe_pkg;

    localparam int LWE_PLAINTEXT_MODULUS  = 64;
    localparam int LWE_PLAINTEXT_WIDTH    = 6;
    localparam int LWE_CIPHERTEXT_MODULUS = 1024;
    localparam int LWE_CIPHERTEXT_WIDTH   = 10;
    localparam int LWE_DIMENSION          = 1;
    localparam int LWE_BIG_N              = 30;
    localparam int LWE_LANES              = 2;

    // Multiplying by q/p is a left shift because both moduli are powers of two.
    localparam int Q_OVER_P_SHIFT = LWE_CIPHERTEXT_WIDTH - LWE_PLAINTEXT_WIDTH;

    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

endpackage

// File: rtl/masked_lane_sum.sv
// rtl/masked_lane_sum.sv - combinational sum of the noise-selected key elements of one beat
module masked_lane_sum #(
    parameter int LANES      = 2,
    parameter int ELEM_WIDTH = 10,
    parameter int SUM_WIDTH  = ELEM_WIDTH + $clog2(LANES + 1)
) (
    input  logic [LANES*ELEM_WIDTH-1:0] data,
    input  logic [LANES-1:0]            mask,
    output logic [SUM_WIDTH-1:0]        sum
);

    // Full-width sum so no lane contribution is lost before the caller reduces mod q.
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                sum = sum + SUM_WIDTH'(data[k*ELEM_WIDTH +: ELEM_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/encrypt_stream.sv
// rtl/encrypt_stream.sv - streaming LWE encrypt: accumulates selected key elements per row, emits DIMENSION+1 ciphertext elements; ENCRYPT_STREAM_ERROR_EN adds a signed error term to the b row
module encrypt_stream
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = LWE_PLAINTEXT_MODULUS,
    parameter int PLAINTEXT_WIDTH    = LWE_PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = LWE_CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = LWE_CIPHERTEXT_WIDTH,
    parameter int DIMENSION          = LWE_DIMENSION,
    parameter int BIG_N              = LWE_BIG_N,
    parameter int LANES              = LWE_LANES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [PLAINTEXT_WIDTH-1:0]          plaintext,
    input  logic [BIG_N-1:0]                    noise_select,
`ifdef ENCRYPT_STREAM_ERROR_EN
    input  logic [3:0]                          err,
`endif
    output logic                                busy,
    input  logic                                pk_valid,
    output logic                                pk_ready,
    input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   pk_data,
    output logic                                ct_valid,
    input  logic                                ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0]         ct_data,
    output logic [$clog2(DIMENSION+1)-1:0]      ct_row,
    output logic                                ct_last
);

    localparam int BEATS     = BIG_N / LANES;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW        = $clog2(DIMENSION + 1);
    localparam int SW        = CIPHERTEXT_WIDTH + $clog2(LANES + 1);
    localparam int MSG_SHIFT = $clog2(CIPHERTEXT_MODULUS) - $clog2(PLAINTEXT_MODULUS);

    state_t                      state;
    logic [CIPHERTEXT_WIDTH-1:0] acc;
    logic [BW-1:0]               beat;
    logic [RW-1:0]               row;
    logic [PLAINTEXT_WIDTH-1:0]  pt_q;
    logic [BIG_N-1:0]            ns_q;

    logic [LANES-1:0]            lane_mask;
    logic [SW-1:0]               lane_sum;
    logic [CIPHERTEXT_WIDTH-1:0] acc_next;
    logic [CIPHERTEXT_WIDTH-1:0] msg_term;
    logic [CIPHERTEXT_WIDTH-1:0] b_value;
    logic                        last_beat;
    logic                        last_row;

    assign busy     = (state != IDLE);
    assign pk_ready = (state == ACCUM);
    assign ct_valid = (state == OUT);

    assign lane_mask = ns_q[int'(beat)*LANES +: LANES];
    assign last_beat = (beat == BW'(BEATS - 1));
    assign last_row  = (row == RW'(DIMENSION));

    masked_lane_sum #(
        .LANES      (LANES),
        .ELEM_WIDTH (CIPHERTEXT_WIDTH),
        .SUM_WIDTH  (SW)
    ) u_lane_sum (
        .data (pk_data),
        .mask (lane_mask),
        .sum  (lane_sum)
    );

    // Reduction mod q is plain truncation since q is a power of two.
    assign acc_next = CIPHERTEXT_WIDTH'(SW'(acc) + lane_sum);
    assign msg_term = CIPHERTEXT_WIDTH'(pt_q) << MSG_SHIFT;

`ifdef ENCRYPT_STREAM_ERROR_EN
    logic [3:0]                  err_q;
    logic [CIPHERTEXT_WIDTH-1:0] err_term;

    assign err_term = {{(CIPHERTEXT_WIDTH-4){err_q[3]}}, err_q};
    assign b_value  = acc_next + msg_term + err_term;

    // Error term is captured together with the plaintext so it stays fixed for the whole encryption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (state == IDLE && start) begin
            err_q <= err;
        end
    end
`else
    assign b_value = acc_next + msg_term;
`endif

    // Control FSM, counters, accumulator and the registered ciphertext output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            beat    <= '0;
            row     <= '0;
            pt_q    <= '0;
            ns_q    <= '0;
            ct_data <= '0;
            ct_row  <= '0;
            ct_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pt_q  <= plaintext;
                        ns_q  <= noise_select;
                        acc   <= '0;
                        beat  <= '0;
                        row   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (pk_valid) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            ct_data <= last_row ? b_value : acc_next;
                            ct_row  <= row;
                            ct_last <= last_row;
                            state   <= OUT;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                OUT: begin
                    if (ct_ready) begin
                        if (ct_last) begin
                            state <= IDLE;
                        end else begin
                            row   <= row + RW'(1);
                            acc   <= '0;
                            beat  <= '0;
                            state <= ACCUM;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_stream.sv
// tb/tb_encrypt_stream.sv - directed self-checking bench for encrypt_stream (BIG_N=4, LANES=2)
module tb_encrypt_stream;

    localparam int PW = 6;
    localparam int CW = 10;
    localparam int BN = 4;
    localparam int LN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PW-1:0]     plaintext;
    logic [BN-1:0]     noise_select;
    logic              busy;
    logic              pk_valid;
    logic              pk_ready;
    logic [LN*CW-1:0]  pk_data;
    logic              ct_valid;
    logic              ct_ready;
    logic [CW-1:0]     ct_data;
    logic [0:0]        ct_row;
    logic              ct_last;
`ifdef ENCRYPT_STREAM_ERROR_EN
    logic [3:0]        err;
`endif

    int checks   = 0;
    int failures = 0;

    encrypt_stream #(
        .BIG_N (BN),
        .LANES (LN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .plaintext    (plaintext),
        .noise_select (noise_select),
`ifdef ENCRYPT_STREAM_ERROR_EN
        .err          (err),
`endif
        .busy         (busy),
        .pk_valid     (pk_valid),
        .pk_ready     (pk_ready),
        .pk_data      (pk_data),
        .ct_valid     (ct_valid),
        .ct_ready     (ct_ready),
        .ct_data      (ct_data),
        .ct_row       (ct_row),
        .ct_last      (ct_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*CW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    task automatic send_beat(input logic [4*CW-1:0] keys, input int b, input bit gap);
        int n = 0;
        if (gap) begin
            pk_valid = 1'b0;
            pk_data  = '1;
            tick();
        end
        pk_data  = keys[b*LN*CW +: LN*CW];
        pk_valid = 1'b1;
        while (!pk_ready && n < 50) begin
            tick();
            n++;
        end
        check("pk_ready_wait", 32'(pk_ready), 1);
        tick();
        pk_valid = 1'b0;
    endtask

    task automatic send_row(input logic [4*CW-1:0] keys, input bit gap);
        send_beat(keys, 0, gap);
        send_beat(keys, 1, gap);
        check("ct_valid_latency", 32'(ct_valid), 1);
    endtask

    task automatic recv(input int exp_data, input int exp_row, input int exp_last,
                        input int stall, input bit start_at_final);
        int n = 0;
        while (!ct_valid && n < 50) begin
            tick();
            n++;
        end
        check("ct_valid", 32'(ct_valid), 1);
        check("ct_data", 32'(ct_data), exp_data);
        check("ct_row", 32'(ct_row), exp_row);
        check("ct_last", 32'(ct_last), exp_last);
        check("pk_ready_in_out", 32'(pk_ready), 0);
        for (int i = 0; i < stall; i++) begin
            ct_ready = 1'b0;
            pk_valid = 1'b1;
            pk_data  = '1;
            tick();
            check("stall_valid", 32'(ct_valid), 1);
            check("stall_data", 32'(ct_data), exp_data);
            check("stall_pk_ready", 32'(pk_ready), 0);
        end
        pk_valid = 1'b0;
        ct_ready = 1'b1;
        if (start_at_final) begin
            start        = 1'b1;
            plaintext    = 6'd7;
            noise_select = 4'b1111;
        end
        tick();
        ct_ready = 1'b0;
        start    = 1'b0;
    endtask

    task automatic encrypt(input int pt, input logic [BN-1:0] ns,
                           input logic [4*CW-1:0] r0, input logic [4*CW-1:0] r1,
                           input int exp0, input int exp1,
                           input bit gap, input int stall, input bit start_at_final);
        plaintext    = PW'(pt);
        noise_select = ns;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
        check("pk_ready_accum", 32'(pk_ready), 1);
        send_row(r0, gap);
        recv(exp0, 0, 0, stall, 1'b0);
        send_row(r1, gap);
        recv(exp1, 1, 1, stall, start_at_final);
        check("busy_fall", 32'(busy), 0);
        tick();
        check("idle_after_final", 32'(busy), 0);
    endtask

    initial begin
        logic [4*CW-1:0] basic0;
        logic [4*CW-1:0] basic1;
        logic [4*CW-1:0] all_max;
        basic0  = pack4(100, 200, 300, 400);
        basic1  = pack4(1000, 10, 50, 7);
        all_max = pack4(1023, 1023, 1023, 1023);

        rst          = 1'b1;
        start        = 1'b0;
        plaintext    = '0;
        noise_select = '0;
        pk_valid     = 1'b0;
        pk_data      = '0;
        ct_ready     = 1'b0;
`ifdef ENCRYPT_STREAM_ERROR_EN
        err          = 4'd0;
`endif
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_pk_ready", 32'(pk_ready), 0);
        check("rst_ct_valid", 32'(ct_valid), 0);
        check("rst_ct_last", 32'(ct_last), 0);
        check("rst_ct_data", 32'(ct_data), 0);
        check("rst_ct_row", 32'(ct_row), 0);
        rst = 1'b0;
        tick();

        // Key beats offered while idle must be ignored.
        pk_valid = 1'b1;
        pk_data  = '1;
        tick();
        check("idle_pk_ready", 32'(pk_ready), 0);
        tick();
        check("idle_busy", 32'(busy), 0);
        pk_valid = 1'b0;

        // Basic: 100+300=400; (1000+50) mod 1024 = 26, +3*16 = 74.
        encrypt(3, 4'b0101, basic0, basic1, 400, 74, 1'b0, 0, 1'b0);

        // Wrap-around: 4*1023 mod 1024 = 1020 on both rows.
        encrypt(0, 4'b1111, all_max, all_max, 1020, 1020, 1'b0, 0, 1'b0);

        // All-zero select: row0 = 0, b = 63*16 = 1008.
        encrypt(63, 4'b0000, basic0, basic1, 0, 1008, 1'b0, 0, 1'b0);

        // Message plus wrapped accumulator: 1020 + 1008 = 2028 mod 1024 = 1004.
        encrypt(63, 4'b1111, all_max, all_max, 1020, 1004, 1'b0, 0, 1'b0);

        // Odd lanes: row0 6+8=14; row1 2+4+42*16 = 678.
        encrypt(42, 4'b1010, pack4(5, 6, 7, 8), pack4(1, 2, 3, 4), 14, 678, 1'b0, 0, 1'b0);

        // Backpressure and gapped key beats.
        encrypt(3, 4'b0101, basic0, basic1, 400, 74, 1'b1, 5, 1'b0);

        // Start coinciding with the final handshake is ignored.
        encrypt(3, 4'b0101, basic0, basic1, 400, 74, 1'b0, 0, 1'b1);
        check("final_start_pk_ready", 32'(pk_ready), 0);

        // Start while busy, mid-row0, must not disturb latched values.
        plaintext    = 6'd3;
        noise_select = 4'b0101;
        start        = 1'b1;
        tick();
        start = 1'b0;
        send_beat(basic0, 0, 1'b0);
        plaintext    = 6'd7;
        noise_select = 4'b1111;
        start        = 1'b1;
        tick();
        start = 1'b0;
        send_beat(basic0, 1, 1'b0);
        recv(400, 0, 0, 0, 1'b0);
        send_row(basic1, 1'b0);
        recv(74, 1, 1, 0, 1'b0);
        check("busy_start_ignored", 32'(busy), 0);

        // Reset during row1 accumulation.
        plaintext    = 6'd3;
        noise_select = 4'b0101;
        start        = 1'b1;
        tick();
        start = 1'b0;
        send_row(basic0, 1'b0);
        recv(400, 0, 0, 0, 1'b0);
        send_beat(basic1, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_pk_ready", 32'(pk_ready), 0);
        check("midrst_ct_valid", 32'(ct_valid), 0);
        check("midrst_ct_data", 32'(ct_data), 0);
        check("midrst_ct_row", 32'(ct_row), 0);
        check("midrst_ct_last", 32'(ct_last), 0);
        tick();
        rst = 1'b0;
        tick();
        pk_data  = basic1[LN*CW +: LN*CW];
        pk_valid = 1'b1;
        tick();
        pk_valid = 1'b0;
        check("post_rst_idle", 32'(busy), 0);
        encrypt(3, 4'b0101, basic0, basic1, 400, 74, 1'b0, 0, 1'b0);

`ifdef ENCRYPT_STREAM_ERROR_EN
        // Error term -2 on the b row only: 74 - 2 = 72.
        err = 4'b1110;
        encrypt(3, 4'b0101, basic0, basic1, 400, 72, 1'b0, 0, 1'b0);
        err = 4'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
